// File: rtl/btb_pkg.sv
// Shared geometry defaults, entry layout and address/counter helpers for the
// set-associative branch target buffer.
package btb_pkg;

    localparam int BTB_INDEX_WIDTH   = 4;
    localparam int BTB_ASSOCIATIVITY = 4;
    localparam int BTB_ADDR_WIDTH    = 32;
    localparam int BTB_CTR_WIDTH     = 2;

    localparam int TAG_WIDTH  = BTB_ADDR_WIDTH - BTB_INDEX_WIDTH - 2;
    localparam int DEPTH      = 2 ** BTB_INDEX_WIDTH;
    localparam int PLRU_WIDTH = BTB_ASSOCIATIVITY - 1;

    typedef struct packed {
        logic                      valid;
        logic [TAG_WIDTH-1:0]      tag;
        logic [BTB_ADDR_WIDTH-1:0] target;
        logic [BTB_CTR_WIDTH-1:0]  ctr;
    } btb_entry_t;

    // Helpers work on wide containers so any module geometry can truncate the result.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned index_w);
        return (pc >> 2) & ((64'd1 << index_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned index_w);
        return pc >> (index_w + 2);
    endfunction

    function automatic logic [7:0] ctr_sat(input logic [7:0] ctr, input logic taken,
                                           input int unsigned ctr_w);
        logic [7:0] ctr_max;
        ctr_max = (8'd1 << ctr_w) - 8'd1;
        if (taken) begin
            return (ctr == ctr_max) ? ctr : ctr + 8'd1;
        end
        return (ctr == 8'd0) ? ctr : ctr - 8'd1;
    endfunction

endpackage

// File: rtl/btb_plru_tree.sv
// Tree pseudo-LRU for one set: applies an optional touch of one way and reports
// the victim the incoming tree state points at.
module btb_plru_tree
    import btb_pkg::*;
#(
    parameter  int WAYS   = BTB_ASSOCIATIVITY,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int PLRU_W = WAYS - 1
) (
    input  logic [PLRU_W-1:0] plru_i,
    input  logic [WAY_W-1:0]  touch_way_i,
    input  logic              touch_en_i,
    output logic [PLRU_W-1:0] plru_o,
    output logic [WAY_W-1:0]  victim_o
);

    // Heap-ordered nodes (root = node 1, stored at bit 0); bit 0 steers left, 1 right.
    always_comb begin : touch_walk
        int node;
        plru_o = plru_i;
        node   = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            for (int b = 0; b < PLRU_W; b++) begin
                if (touch_en_i && (b == node - 1)) begin
                    plru_o[b] = ~touch_way_i[WAY_W-1-lvl];
                end
            end
            node = 2 * node + (touch_way_i[WAY_W-1-lvl] ? 1 : 0);
        end
    end

    always_comb begin : victim_walk
        int   node;
        logic dir;
        victim_o = '0;
        node     = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir = 1'b0;
            for (int b = 0; b < PLRU_W; b++) begin
                if (b == node - 1) begin
                    dir = plru_i[b];
                end
            end
            victim_o[WAY_W-1-lvl] = dir;
            node = 2 * node + (dir ? 1 : 0);
        end
    end

endmodule

// File: rtl/btb_nway_plru.sv
// N-way set-associative BTB with tree PLRU replacement and saturating direction
// counters; one-cycle registered lookup beside fetch, training port from execute.
module btb_nway_plru
    import btb_pkg::*;
#(
    parameter int INDEX_WIDTH   = BTB_INDEX_WIDTH,
    parameter int ASSOCIATIVITY = BTB_ASSOCIATIVITY,
    parameter int ADDR_WIDTH    = BTB_ADDR_WIDTH,
    parameter int CTR_WIDTH     = BTB_CTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_lookup_valid,
    input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
    output logic                  o_valid,
    output logic                  o_hit,
    output logic                  o_taken,
    output logic [ADDR_WIDTH-1:0] o_target,
    input  logic                  i_update_valid,
    input  logic [ADDR_WIDTH-1:0] i_update_pc,
    input  logic                  i_update_taken,
    input  logic [ADDR_WIDTH-1:0] i_update_target,
    input  logic                  i_flush
);

    localparam int SETS   = 2 ** INDEX_WIDTH;
    localparam int TAG_W  = ADDR_WIDTH - INDEX_WIDTH - 2;
    localparam int PLRU_W = ASSOCIATIVITY - 1;
    localparam int WAY_W  = $clog2(ASSOCIATIVITY);
    localparam logic [CTR_WIDTH-1:0] CTR_WEAK_TAKEN = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

    logic [ASSOCIATIVITY-1:0] valid_q  [SETS];
    logic [PLRU_W-1:0]        plru_q   [SETS];
    logic [TAG_W-1:0]         tag_q    [SETS][ASSOCIATIVITY];
    logic [ADDR_WIDTH-1:0]    target_q [SETS][ASSOCIATIVITY];
    logic [CTR_WIDTH-1:0]     ctr_q    [SETS][ASSOCIATIVITY];

    logic                  o_valid_q, o_hit_q, o_taken_q;
    logic [ADDR_WIDTH-1:0] o_target_q, o_target_d;

    logic [INDEX_WIDTH-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0]         lk_tag, up_tag;
    logic [ASSOCIATIVITY-1:0] lk_hit_vec, up_hit_vec;
    logic [WAY_W-1:0]         lk_way, up_way, up_free_way, up_victim, alloc_way, up_way_sel;
    logic [ADDR_WIDTH-1:0]    lk_target;
    logic                     lk_taken, lk_hit, up_hit, up_free;
    logic                     up_en, up_wr_hit, up_alloc;
    logic [PLRU_W-1:0]        lk_plru_next, up_plru_in, up_plru_next;
    logic [WAY_W-1:0]         lk_victim_unused;
    logic [CTR_WIDTH-1:0]     ctr_d;

    assign lk_idx = INDEX_WIDTH'(pc_index(64'(i_lookup_pc), INDEX_WIDTH));
    assign lk_tag = TAG_W'(pc_tag(64'(i_lookup_pc), INDEX_WIDTH));
    assign up_idx = INDEX_WIDTH'(pc_index(64'(i_update_pc), INDEX_WIDTH));
    assign up_tag = TAG_W'(pc_tag(64'(i_update_pc), INDEX_WIDTH));

    // Lookup reads the pre-edge arrays; tags are unique per set so the OR-mux is one-hot.
    always_comb begin
        lk_hit_vec = '0;
        lk_target  = '0;
        lk_taken   = 1'b0;
        lk_way     = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            lk_hit_vec[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
            lk_target     = lk_target | (target_q[lk_idx][w] & {ADDR_WIDTH{lk_hit_vec[w]}});
            lk_taken      = lk_taken | (lk_hit_vec[w] & ctr_q[lk_idx][w][CTR_WIDTH-1]);
            if (lk_hit_vec[w]) begin
                lk_way = WAY_W'(w);
            end
        end
    end

    assign lk_hit     = i_lookup_valid & (|lk_hit_vec);
    assign o_target_d = lk_hit ? lk_target : '0;

    always_comb begin
        up_hit_vec = '0;
        up_way     = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            up_hit_vec[w] = valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag);
            if (up_hit_vec[w]) begin
                up_way = WAY_W'(w);
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        up_free     = 1'b0;
        up_free_way = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (!valid_q[up_idx][w]) begin
                up_free     = 1'b1;
                up_free_way = WAY_W'(w);
            end
        end
    end

    assign up_hit     = |up_hit_vec;
    assign up_en      = i_update_valid & ~i_flush;
    assign up_wr_hit  = up_en & up_hit;
    assign up_alloc   = up_en & ~up_hit & i_update_taken;
    assign alloc_way  = up_free ? up_free_way : up_victim;
    assign up_way_sel = up_hit ? up_way : alloc_way;

    assign ctr_d = up_alloc ? CTR_WEAK_TAKEN
                            : CTR_WIDTH'(ctr_sat(8'(ctr_q[up_idx][up_way]), i_update_taken, CTR_WIDTH));

    btb_plru_tree #(.WAYS(ASSOCIATIVITY)) u_plru_lookup (
        .plru_i      (plru_q[lk_idx]),
        .touch_way_i (lk_way),
        .touch_en_i  (lk_hit),
        .plru_o      (lk_plru_next),
        .victim_o    (lk_victim_unused)
    );

    // Chaining through the lookup result lets the update touch override shared path bits.
    assign up_plru_in = (lk_idx == up_idx) ? lk_plru_next : plru_q[up_idx];

    btb_plru_tree #(.WAYS(ASSOCIATIVITY)) u_plru_update (
        .plru_i      (up_plru_in),
        .touch_way_i (up_way_sel),
        .touch_en_i  (up_wr_hit | up_alloc),
        .plru_o      (up_plru_next),
        .victim_o    (up_victim)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            o_valid_q  <= 1'b0;
            o_hit_q    <= 1'b0;
            o_taken_q  <= 1'b0;
            o_target_q <= '0;
        end else begin
            if (i_flush) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end else if (up_alloc) begin
                valid_q[up_idx][alloc_way] <= 1'b1;
            end
            // Second write wins when both ports address the same set.
            plru_q[lk_idx] <= lk_plru_next;
            plru_q[up_idx] <= up_plru_next;
            o_valid_q  <= i_lookup_valid;
            o_hit_q    <= lk_hit;
            o_taken_q  <= lk_hit & lk_taken;
            o_target_q <= o_target_d;
        end
    end

    always_ff @(posedge clk) begin
        if (up_wr_hit || up_alloc) begin
            target_q[up_idx][up_way_sel] <= i_update_target;
            ctr_q[up_idx][up_way_sel]    <= ctr_d;
            if (up_alloc) begin
                tag_q[up_idx][up_way_sel] <= up_tag;
            end
        end
    end

    assign o_valid  = o_valid_q;
    assign o_hit    = o_hit_q;
    assign o_taken  = o_taken_q;
    assign o_target = o_target_q;

endmodule

// File: tb/tb_btb_nway_plru.sv
// Directed bench for btb_nway_plru: a table of one-cycle vectors plus an
// asynchronous-reset sequence.
module tb_btb_nway_plru;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_lookup_valid;
    logic [31:0] i_lookup_pc;
    logic        o_valid, o_hit, o_taken;
    logic [31:0] o_target;
    logic        i_update_valid;
    logic [31:0] i_update_pc;
    logic        i_update_taken;
    logic [31:0] i_update_target;
    logic        i_flush;

    always #5 clk = ~clk;

    btb_nway_plru #(
        .INDEX_WIDTH(4), .ASSOCIATIVITY(4), .ADDR_WIDTH(32), .CTR_WIDTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_lookup_valid(i_lookup_valid), .i_lookup_pc(i_lookup_pc),
        .o_valid(o_valid), .o_hit(o_hit), .o_taken(o_taken), .o_target(o_target),
        .i_update_valid(i_update_valid), .i_update_pc(i_update_pc),
        .i_update_taken(i_update_taken), .i_update_target(i_update_target),
        .i_flush(i_flush)
    );

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        fl;
        logic        ev;
        logic        eh;
        logic        et;
        logic [31:0] etg;
        string       name;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [34:0] outs();
        return {o_valid, o_hit, o_taken, o_target};
    endfunction

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got valid=%0b hit=%0b taken=%0b target=%h, expected valid=%0b hit=%0b taken=%0b target=%h",
                     name, act[34], act[33], act[32], act[31:0], exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    function automatic vec_t mk(input logic lv, input logic [31:0] lpc, input logic uv,
                                input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                                input logic fl, input logic ev, input logic eh, input logic et,
                                input logic [31:0] etg, input string name);
        vec_t v;
        v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.fl = fl;
        v.ev = ev; v.eh = eh; v.et = et; v.etg = etg; v.name = name;
        return v;
    endfunction

    // Lookup-only vector; a miss expects taken=0 and target=0.
    function automatic vec_t lk(input logic [31:0] pc, input logic h, input logic t,
                                input logic [31:0] tg, input string name);
        return mk(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, h, t, tg, name);
    endfunction

    // Update-only vector; no lookup so the next cycle shows all-zero outputs.
    function automatic vec_t up(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                                input string name);
        return mk(1'b0, 32'h0, 1'b1, pc, t, tg, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, name);
    endfunction

    task automatic idle();
        i_lookup_valid  = 1'b0;
        i_lookup_pc     = 32'h0;
        i_update_valid  = 1'b0;
        i_update_pc     = 32'h0;
        i_update_taken  = 1'b0;
        i_update_target = 32'h0;
        i_flush         = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        i_lookup_valid  = v.lv;
        i_lookup_pc     = v.lpc;
        i_update_valid  = v.uv;
        i_update_pc     = v.upc;
        i_update_taken  = v.ut;
        i_update_target = v.utg;
        i_flush         = v.fl;
        @(posedge clk);
        #1;
        check(v.name, outs(), {v.ev, v.eh, v.et, v.etg});
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        check("reset_state", outs(), 35'h0);
        #10;
        rst_n = 1'b1;

        // Cold miss, allocation, counter training and saturation at both ends.
        tbl.push_back(lk(32'h1000, 0, 0, 32'h0,    "cold_miss"));
        tbl.push_back(up(32'h1000, 1, 32'h2000,    "alloc_1000"));
        tbl.push_back(lk(32'h1000, 1, 1, 32'h2000, "hit_weak_taken"));
        tbl.push_back(up(32'h1000, 0, 32'h2000,    "nt_ctr1"));
        tbl.push_back(up(32'h1000, 0, 32'h2000,    "nt_ctr0"));
        tbl.push_back(up(32'h1000, 0, 32'h2000,    "nt_floor"));
        tbl.push_back(lk(32'h1000, 1, 0, 32'h2000, "hit_ctr_floor"));
        tbl.push_back(up(32'h1000, 1, 32'h2000,    "t_ctr1"));
        tbl.push_back(up(32'h1000, 1, 32'h2000,    "t_ctr2"));
        tbl.push_back(up(32'h1000, 1, 32'h2000,    "t_ctr3"));
        tbl.push_back(up(32'h1000, 1, 32'h2000,    "t_ceiling"));
        tbl.push_back(up(32'h1000, 0, 32'h2000,    "nt_ctr2"));
        tbl.push_back(up(32'h1000, 0, 32'h2000,    "nt_ctr1b"));
        tbl.push_back(lk(32'h1000, 1, 0, 32'h2000, "hit_after_ceiling"));
        tbl.push_back(up(32'h1000, 1, 32'h3000,    "retarget"));
        tbl.push_back(lk(32'h1003, 1, 1, 32'h3000, "low_bits_ignored"));
        tbl.push_back(up(32'h5000, 0, 32'h5555,    "nt_miss_no_alloc"));
        tbl.push_back(lk(32'h5000, 0, 0, 32'h0,    "nt_miss_check"));
        tbl.push_back(mk(0, 32'h1000, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, "no_lookup_no_hit"));
        tbl.push_back(mk(1, 32'h1000, 0, 32'h0, 0, 32'h0, 1, 1, 1, 1, 32'h3000, "flush_prelook"));
        tbl.push_back(lk(32'h1000, 0, 0, 32'h0,    "post_flush_miss"));
        // Fill set 0, touch ways 0 and 2, then the PLRU victim must be way 1.
        tbl.push_back(up(32'h0000, 1, 32'h8000,    "fill0_w0"));
        tbl.push_back(up(32'h0040, 1, 32'h8040,    "fill0_w1"));
        tbl.push_back(up(32'h0080, 1, 32'h8080,    "fill0_w2"));
        tbl.push_back(up(32'h00C0, 1, 32'h80C0,    "fill0_w3"));
        tbl.push_back(lk(32'h0000, 1, 1, 32'h8000, "touch0_w0"));
        tbl.push_back(lk(32'h0080, 1, 1, 32'h8080, "touch0_w2"));
        tbl.push_back(up(32'h0100, 1, 32'h8100,    "evict0_alloc"));
        tbl.push_back(lk(32'h0000, 1, 1, 32'h8000, "evict0_keep_w0"));
        tbl.push_back(lk(32'h0080, 1, 1, 32'h8080, "evict0_keep_w2"));
        tbl.push_back(lk(32'h0100, 1, 1, 32'h8100, "evict0_new"));
        tbl.push_back(lk(32'h0040, 0, 0, 32'h0,    "evict0_victim_gone"));
        // Same-cycle lookup and allocating update: lookup sees the old state.
        tbl.push_back(mk(1, 32'h1000, 1, 32'h1000, 1, 32'h2000, 0, 1, 0, 0, 32'h0, "rbw_same_cycle"));
        tbl.push_back(lk(32'h1000, 1, 1, 32'h2000, "rbw_next_cycle"));
        // Set 5: concurrent lookup touch (way 0) and update touch (way 3); update owns the root.
        tbl.push_back(up(32'h0014, 1, 32'h9014,    "fill5_w0"));
        tbl.push_back(up(32'h0054, 1, 32'h9054,    "fill5_w1"));
        tbl.push_back(up(32'h0094, 1, 32'h9094,    "fill5_w2"));
        tbl.push_back(up(32'h00D4, 1, 32'h90D4,    "fill5_w3"));
        tbl.push_back(mk(1, 32'h0014, 1, 32'h00D4, 1, 32'h90D4, 0, 1, 1, 1, 32'h9014, "dual_touch"));
        tbl.push_back(up(32'h0114, 1, 32'h9114,    "evict5_alloc"));
        tbl.push_back(lk(32'h0054, 0, 0, 32'h0,    "evict5_victim_w1"));
        tbl.push_back(lk(32'h0094, 1, 1, 32'h9094, "evict5_keep_w2"));
        tbl.push_back(lk(32'h0014, 1, 1, 32'h9014, "evict5_keep_w0"));
        tbl.push_back(lk(32'h0114, 1, 1, 32'h9114, "evict5_new"));
        // Flush together with an update of a new PC: everything misses afterwards.
        tbl.push_back(up(32'h2004, 1, 32'hA004,    "pop_1"));
        tbl.push_back(up(32'h2008, 1, 32'hA008,    "pop_2"));
        tbl.push_back(up(32'h200C, 1, 32'hA00C,    "pop_3"));
        tbl.push_back(lk(32'h2008, 1, 1, 32'hA008, "pop_hit"));
        tbl.push_back(mk(0, 32'h0, 1, 32'h3010, 1, 32'hB010, 1, 0, 0, 0, 32'h0, "flush_with_update"));
        tbl.push_back(lk(32'h2004, 0, 0, 32'h0,    "flushed_1"));
        tbl.push_back(lk(32'h2008, 0, 0, 32'h0,    "flushed_2"));
        tbl.push_back(lk(32'h200C, 0, 0, 32'h0,    "flushed_3"));
        tbl.push_back(lk(32'h3010, 0, 0, 32'h0,    "flush_dropped_update"));
        tbl.push_back(lk(32'h1000, 0, 0, 32'h0,    "flushed_1000"));

        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        // Asynchronous reset between edges while a hit is being presented.
        apply(up(32'h1000, 1, 32'h2000,    "rst_pop_a"));
        apply(up(32'h2004, 1, 32'hA004,    "rst_pop_b"));
        apply(lk(32'h1000, 1, 1, 32'h2000, "pre_reset_hit"));
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", outs(), 35'h0);
        #2;
        rst_n = 1'b1;
        apply(lk(32'h1000, 0, 0, 32'h0, "post_reset_miss_a"));
        apply(lk(32'h2004, 0, 0, 32'h0, "post_reset_miss_b"));
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
